// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with occupancy count, thresholds, sticky errors; FWFT mode when FIFO_SYNC_FWFT_EN is defined
module fifo_sync #(
   parameter int FIFO_DATA_WIDTH   = 8,
   parameter int FIFO_BUFFER_SIZE  = 1024,
   parameter int FIFO_AFULL_LEVEL  = FIFO_BUFFER_SIZE - 4,
   parameter int FIFO_AEMPTY_LEVEL = 4,
   localparam int CW = $clog2(FIFO_BUFFER_SIZE) + 1
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       wr_en,
   input  logic [FIFO_DATA_WIDTH-1:0] din,
   output logic                       full,
   output logic                       almost_full,
   input  logic                       rd_en,
   output logic [FIFO_DATA_WIDTH-1:0] dout,
   output logic                       empty,
   output logic                       almost_empty,
   output logic [CW-1:0]              count,
   output logic                       overflow,
   output logic                       underflow,
   input  logic                       clr_err
);

   localparam int AW = CW - 1;
   localparam logic [CW-1:0] AFULL_LVL  = CW'(FIFO_AFULL_LEVEL);
   localparam logic [CW-1:0] AEMPTY_LVL = CW'(FIFO_AEMPTY_LEVEL);
   localparam logic [CW-1:0] PTR_ONE    = CW'(1);

   // Storage array; deliberately not reset so it maps onto RAM.
   logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_BUFFER_SIZE];

   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;

   logic          wr_accept;
   logic          rd_accept;
   logic          empty_w;
   logic          full_w;
   logic [CW-1:0] count_w;
   logic [FIFO_DATA_WIDTH-1:0] rd_word;

   // Any bit that is not a clean 1 (0, X or Z) is forced to 0.
   function automatic logic [FIFO_DATA_WIDTH-1:0] x_scrub(input logic [FIFO_DATA_WIDTH-1:0] v);
      logic [FIFO_DATA_WIDTH-1:0] r;
      r = '0;
      for (int i = 0; i < FIFO_DATA_WIDTH; i++) begin
         r[i] = (v[i] === 1'b1);
      end
      return r;
   endfunction

   // Status derived only from registered pointers: no path from wr_en/rd_en.
   always_comb begin
      empty_w  = (wr_ptr_q == rd_ptr_q);
      full_w   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      count_w  = wr_ptr_q - rd_ptr_q;
      rd_word  = x_scrub(mem[rd_ptr_q[AW-1:0]]);
   end

   // Accept decisions, pointer advance and sticky error flags (set beats clear).
   always_comb begin
      wr_accept   = wr_en && !full_w;
      rd_accept   = rd_en && !empty_w;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      if (wr_accept) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_accept) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      overflow_d  = (wr_en && full_w)  || (overflow_q  && !clr_err);
      underflow_d = (rd_en && empty_w) || (underflow_q && !clr_err);
   end

   // Pointer and error-flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Array write on an accepted write.
   always_ff @(posedge clk) begin
      if (wr_accept) begin
         mem[wr_ptr_q[AW-1:0]] <= din;
      end
   end

`ifdef FIFO_SYNC_FWFT_EN
   // Head word is presented combinationally whenever data is present.
   always_comb begin
      dout = empty_w ? '0 : rd_word;
   end
`else
   logic [FIFO_DATA_WIDTH-1:0] dout_q, dout_d;

   // Registered read data loads only on an accepted read, otherwise holds.
   always_comb begin
      dout_d = rd_accept ? rd_word : dout_q;
   end

   // Read data register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   // Output drive of the registered read data.
   always_comb begin
      dout = dout_q;
   end
`endif

   // Output drive of flags, occupancy and thresholds.
   always_comb begin
      empty        = empty_w;
      full         = full_w;
      count        = count_w;
      almost_full  = (count_w >= AFULL_LVL);
      almost_empty = (count_w <= AEMPTY_LVL);
      overflow     = overflow_q;
      underflow    = underflow_q;
   end

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - directed table and sequence checks for fifo_sync (8 words deep)
module tb_fifo_sync;

   localparam int W  = 8;
   localparam int D  = 8;
   localparam int CW = 4;
`ifdef FIFO_SYNC_FWFT_EN
   localparam bit FWFT = 1'b1;
`else
   localparam bit FWFT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          clr_err = 1'b0;
   logic [W-1:0]  din = '0;
   logic          full, almost_full, empty, almost_empty, overflow, underflow;
   logic [W-1:0]  dout;
   logic [CW-1:0] count;

   int n_pass  = 0;
   int n_total = 0;

   fifo_sync #(
      .FIFO_DATA_WIDTH   (W),
      .FIFO_BUFFER_SIZE  (D),
      .FIFO_AFULL_LEVEL  (4),
      .FIFO_AEMPTY_LEVEL (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .wr_en        (wr_en),
      .din          (din),
      .full         (full),
      .almost_full  (almost_full),
      .rd_en        (rd_en),
      .dout         (dout),
      .empty        (empty),
      .almost_empty (almost_empty),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow),
      .clr_err      (clr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic          rd;
      logic [W-1:0]  din;
      logic [CW-1:0] c;
      logic          e;
      logic          f;
      logic          af;
      logic          ae;
      logic [W-1:0]  d_std;
      logic [W-1:0]  d_fwft;
   } vec_t;

   vec_t tbl [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] st(input int c, input logic e, input logic f,
                                      input logic af, input logic ae, input logic ov, input logic un);
      return {22'd0, 4'(c), e, f, af, ae, ov, un};
   endfunction

   function automatic logic [31:0] status();
      return {22'd0, count, empty, full, almost_full, almost_empty, overflow, underflow};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pop one word: FWFT data is judged before the pop edge, standard data after it.
   task automatic pop(input logic [W-1:0] exp, input string name);
      logic [W-1:0] pre;
      rd_en = 1'b1;
      pre = dout;
      step();
      chk(name, FWFT ? pre : dout, exp);
      rd_en = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached before summary");
      $fatal(1);
   end

   initial begin
      logic [W-1:0] xv;
      logic [W-1:0] expx;

      tbl[0] = '{1'b1, 1'b0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01};
      tbl[1] = '{1'b1, 1'b0, 8'h02, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h01};
      tbl[2] = '{1'b1, 1'b0, 8'h03, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01};
      tbl[3] = '{1'b1, 1'b0, 8'h04, 4'd4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h01};
      tbl[4] = '{1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h02};
      tbl[5] = '{1'b0, 1'b1, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 8'h02, 8'h03};
      tbl[6] = '{1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 8'h04};
      tbl[7] = '{1'b0, 1'b1, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 8'h00};

      // reset state
      step();
      step();
      chk("reset_status", status(), st(0, 1, 0, 0, 1, 0, 0));
      chk("reset_dout", 32'(dout), 32'h0);
      reset_n = 1'b1;

      // basic write 4 / read 4
      for (int i = 0; i < 8; i++) begin
         wr_en = tbl[i].wr;
         rd_en = tbl[i].rd;
         din   = tbl[i].din;
         step();
         chk($sformatf("tbl%0d_status", i), status(),
             st(int'(tbl[i].c), tbl[i].e, tbl[i].f, tbl[i].af, tbl[i].ae, 1'b0, 1'b0));
         chk($sformatf("tbl%0d_dout", i), 32'(dout), 32'(FWFT ? tbl[i].d_fwft : tbl[i].d_std));
      end
      wr_en = 1'b0;
      rd_en = 1'b0;

      // fill to full, overflow on 9th write
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1;
         din   = 8'hA0 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      chk("fill_status", status(), st(8, 0, 1, 1, 0, 0, 0));
      wr_en = 1'b1;
      din   = 8'hFF;
      step();
      wr_en = 1'b0;
      chk("overflow_status", status(), st(8, 0, 1, 1, 0, 1, 0));

      // full with wr+rd: only the read is accepted
      wr_en = 1'b1;
      din   = 8'hEE;
      pop(8'hA0, "full_wr_rd_data");
      wr_en = 1'b0;
      chk("full_wr_rd_status", status(), st(7, 0, 0, 1, 0, 1, 0));
      for (int i = 1; i < 8; i++) pop(8'hA0 + 8'(i), $sformatf("drain%0d", i));
      chk("drained_status", status(), st(0, 1, 0, 0, 1, 1, 0));

      // empty with wr+rd: only the write is accepted
      wr_en = 1'b1;
      rd_en = 1'b1;
      din   = 8'h55;
      step();
      wr_en = 1'b0;
      rd_en = 1'b0;
      chk("empty_wr_rd_status", status(), st(1, 0, 0, 0, 1, 1, 1));
      chk("empty_wr_rd_dout", 32'(dout), 32'(FWFT ? 8'h55 : 8'hA7));
      pop(8'h55, "empty_wr_rd_data");

      // clr_err
      clr_err = 1'b1;
      step();
      clr_err = 1'b0;
      chk("clr_err_status", status(), st(0, 1, 0, 0, 1, 0, 0));

      // streaming across pointer wrap
      wr_en = 1'b1;
      din   = 8'h10;
      step();
      for (int k = 0; k < 3 * D; k++) begin
         wr_en = 1'b1;
         din   = 8'h11 + 8'(k);
         pop(8'h10 + 8'(k), $sformatf("stream%0d", k));
         chk($sformatf("stream%0d_count", k), 32'(count), 32'd1);
      end
      wr_en = 1'b0;
      chk("stream_status", status(), st(1, 0, 0, 0, 1, 0, 0));
      pop(8'h28, "stream_last");

      // X scrub: expectation follows what the simulator made of the X bit
      xv    = {7'b0, 1'bx};
      din   = xv;
      wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      expx  = (din[0] === 1'b1) ? 8'h01 : 8'h00;
      pop(expx, "xscrub");

      // underflow, then reset mid-operation
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      chk("underflow_status", status(), st(0, 1, 0, 0, 1, 0, 1));
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1;
         din   = 8'h31 + 8'(i);
         step();
      end
      wr_en = 1'b0;
      pop(8'h31, "pre_reset_data");
      chk("pre_reset_status", status(), st(4, 0, 0, 1, 0, 0, 1));
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_reset_status", status(), st(0, 1, 0, 0, 1, 0, 0));
      chk("async_reset_dout", 32'(dout), 32'h0);
      step();
      reset_n = 1'b1;
      rd_en   = 1'b1;
      step();
      rd_en = 1'b0;
      chk("post_reset_underflow", status(), st(0, 1, 0, 0, 1, 0, 1));
      wr_en = 1'b1;
      din   = 8'h77;
      step();
      wr_en = 1'b0;
      chk("post_reset_write_count", 32'(count), 32'd1);
      pop(8'h77, "post_reset_data");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
